lab3_cache_mem_responder: RTL and testbench

- Cache-side responder for the 4B memory request/response protocol.
- Sits at the far end of the processor→cache path: it accepts `mem_req_4B_t` requests, services them from an internal word array after a fixed latency, and returns `mem_resp_4B_t` responses.
- Also acknowledges flush requests with a `flush_done` pulse once all outstanding work has drained.
- Used as the target for cache/bypass integration tests and as a stand-in for a real cache.

---
 rtl/lab3_cache_mem_responder.sv | 130 +++++++++++++
 tb/tb_lab3_cache_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_cache_mem_responder.sv
// Cache-side responder for the 4B memory request/response protocol: services one
// request at a time from a word array after a fixed latency and acknowledges flushes.
module lab3_cache_mem_responder #(
    parameter int NUM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [76:0] memreq_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [46:0] memresp_msg,
    input  logic        flush,
    output logic        flush_done
);

    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic             flush_pending;
    logic [46:0]      resp_msg;
    logic [31:0]      mem [NUM_WORDS];

    logic [2:0]       req_type;
    logic [7:0]       req_opaque;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       offset;
    logic [1:0]       req_len;
    logic [31:0]      req_data;
    logic [2:0]       nbytes;
    logic [2:0]       lane_end;
    logic [31:0]      cur_word;
    logic [31:0]      wdata_shifted;
    logic [31:0]      rdata_shifted;
    logic [31:0]      new_word;
    logic [31:0]      rdata_masked;
    logic             is_read;
    logic             is_write;
    logic             xfer;

    assign req_type   = memreq_msg[76:74];
    assign req_opaque = memreq_msg[73:66];
    assign word_idx   = memreq_msg[IDX_W+35:36];
    assign offset     = memreq_msg[35:34];
    assign req_len    = memreq_msg[33:32];
    assign req_data   = memreq_msg[31:0];

    // Address bits above the word index are ignored so accesses wrap around the array.
    generate
        if (IDX_W < 30) begin : g_unused_addr
            logic unused_addr_bits;
            assign unused_addr_bits = &{1'b0, memreq_msg[65:IDX_W+36]};
        end
    endgenerate

    assign nbytes   = (req_len == 2'd0) ? 3'd4 : {1'b0, req_len};
    assign lane_end = {1'b0, offset} + nbytes;
    assign cur_word = mem[word_idx];
    assign is_read  = (req_type == 3'd0);
    assign is_write = (req_type == 3'd1) || (req_type == 3'd2);

    // Byte lanes past lane 3 simply fall off; an access never spills into the next word.
    always_comb begin
        wdata_shifted = req_data << {offset, 3'b000};
        rdata_shifted = cur_word >> {offset, 3'b000};
        new_word      = cur_word;
        rdata_masked  = '0;
        for (int b = 0; b < 4; b++) begin
            if ((3'(b) >= {1'b0, offset}) && (3'(b) < lane_end))
                new_word[8*b +: 8] = wdata_shifted[8*b +: 8];
            if (3'(b) < nbytes)
                rdata_masked[8*b +: 8] = rdata_shifted[8*b +: 8];
        end
    end

    // A pending flush blocks new requests until its acknowledge has been issued.
    assign memreq_rdy  = !reset && (state == IDLE) && !flush && !flush_pending;
    assign memresp_val = !reset && (state == RESP);
    assign flush_done  = !reset && (state == IDLE) && flush_pending;
    assign memresp_msg = resp_msg;
    assign xfer        = memreq_val && memreq_rdy;

    // Array storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (xfer && is_write)
            mem[word_idx] <= new_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= '0;
            flush_pending <= 1'b0;
            resp_msg      <= '0;
        end else begin
            if (flush_done)
                flush_pending <= 1'b0;
            else if (flush)
                flush_pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (xfer) begin
                        resp_msg <= {req_type, req_opaque, 2'b00, req_len,
                                     is_read ? rdata_masked : 32'h0};
                        counter  <= CNT_W'(LATENCY - 1);
                        state    <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    counter <= counter - 1'b1;
                    if (counter == CNT_W'(1))
                        state <= RESP;
                end
                RESP: begin
                    if (memresp_rdy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_cache_mem_responder.sv
// Self-checking bench for lab3_cache_mem_responder: directed protocol scenarios plus
// randomized traffic checked against a byte-level model of the word array.
module tb_lab3_cache_mem_responder;

    localparam int NUM_WORDS = 256;
    localparam int LATENCY   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [76:0] memreq_msg;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [46:0] memresp_msg;
    logic        flush;
    logic        flush_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [NUM_WORDS];

    lab3_cache_mem_responder #(
        .NUM_WORDS (NUM_WORDS),
        .LATENCY   (LATENCY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memreq_msg  (memreq_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .memresp_msg (memresp_msg),
        .flush       (flush),
        .flush_done  (flush_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: walks the requested bytes one at a time, dropping any past lane 3.
    function automatic logic [46:0] modelAccess(input logic [2:0] typ, input logic [7:0] op,
                                                input logic [31:0] addr, input logic [1:0] len,
                                                input logic [31:0] data);
        int          idx = int'((addr >> 2) % NUM_WORDS);
        int          off = int'(addr & 32'd3);
        int          nb  = (len == 2'd0) ? 4 : int'(len);
        logic [31:0] rd  = '0;
        for (int k = 0; k < nb; k++) begin
            if (off + k < 4) begin
                if (typ == 3'd0)
                    rd[8*k +: 8] = model_mem[idx][8*(off+k) +: 8];
                else if (typ == 3'd1 || typ == 3'd2)
                    model_mem[idx][8*(off+k) +: 8] = data[8*k +: 8];
            end
        end
        return {typ, op, 2'b00, len, (typ == 3'd0) ? rd : 32'h0};
    endfunction

    // One complete transaction: issue, latency, optional backpressure and mid-wait flush, handshake.
    task automatic applyStimulus(input logic [2:0] typ, input logic [7:0] op, input logic [31:0] addr,
                                 input logic [1:0] len, input logic [31:0] data, input int hold,
                                 input bit flush_in_wait, output logic [46:0] got);
        logic [46:0] exp;
        int          waited;
        int          lat;
        memreq_msg = {typ, op, addr, len, data};
        memreq_val = 1'b1;
        waited     = 0;
        got        = '0;
        #1;
        while (!memreq_rdy && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!memreq_rdy) begin
            checkOutput("req_accept_timeout", 64'(memreq_rdy), 64'd1);
            memreq_val = 1'b0;
            return;
        end
        exp = modelAccess(typ, op, addr, len, data);
        @(negedge clk);
        memreq_val = 1'b0;
        if (flush_in_wait)
            flush = 1'b1;
        lat = 1;
        #1;
        while (!memresp_val && lat < 20) begin
            checkOutput("rdy_low_in_wait", 64'(memreq_rdy), 64'd0);
            checkOutput("no_done_in_wait", 64'(flush_done), 64'd0);
            @(negedge clk);
            flush = 1'b0;
            #1;
            lat++;
        end
        flush = 1'b0;
        checkOutput("resp_val", 64'(memresp_val), 64'd1);
        checkOutput("resp_latency", 64'(lat), 64'(LATENCY));
        checkOutput("resp_msg", 64'(memresp_msg), 64'(exp));
        got = memresp_msg;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_val_held", 64'(memresp_val), 64'd1);
            checkOutput("bp_msg_stable", 64'(memresp_msg), 64'(exp));
            checkOutput("bp_rdy_low", 64'(memreq_rdy), 64'd0);
            checkOutput("bp_no_done", 64'(flush_done), 64'd0);
        end
        memresp_rdy = 1'b1;
        @(negedge clk);
        memresp_rdy = 1'b0;
        #1;
        checkOutput("val_low_after_hs", 64'(memresp_val), 64'd0);
        if (flush_in_wait) begin
            checkOutput("flush_done_pulse", 64'(flush_done), 64'd1);
            checkOutput("rdy_low_at_done", 64'(memreq_rdy), 64'd0);
            @(negedge clk);
            #1;
            checkOutput("flush_done_single", 64'(flush_done), 64'd0);
            checkOutput("rdy_after_flush", 64'(memreq_rdy), 64'd1);
        end else begin
            checkOutput("no_flush_done", 64'(flush_done), 64'd0);
            checkOutput("rdy_after_hs", 64'(memreq_rdy), 64'd1);
        end
    endtask

    initial begin
        logic [46:0] resp;
        logic [2:0]  typ;
        int          r;

        reset       = 1'b1;
        memreq_val  = 1'b0;
        memreq_msg  = '0;
        memresp_rdy = 1'b0;
        flush       = 1'b0;

        @(negedge clk);
        #1;
        checkOutput("rst_rdy", 64'(memreq_rdy), 64'd0);
        checkOutput("rst_val", 64'(memresp_val), 64'd0);
        checkOutput("rst_done", 64'(flush_done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("post_rst_rdy", 64'(memreq_rdy), 64'd1);
        checkOutput("post_rst_val", 64'(memresp_val), 64'd0);
        checkOutput("post_rst_done", 64'(flush_done), 64'd0);

        // Give every word a known value so random reads have defined expectations.
        for (int i = 0; i < NUM_WORDS; i++)
            applyStimulus(3'd2, 8'(i), 32'(i * 4), 2'd0, $urandom, 0, 1'b0, resp);

        // Write then read back a full word.
        applyStimulus(3'd1, 8'h05, 32'h0000_0010, 2'd0, 32'hDEADBEEF, 0, 1'b0, resp);
        checkOutput("t1_write_resp", 64'(resp), 64'({3'd1, 8'h05, 2'b00, 2'd0, 32'h0}));
        applyStimulus(3'd0, 8'h06, 32'h0000_0010, 2'd0, 32'h0, 0, 1'b0, resp);
        checkOutput("t1_read_data", 64'(resp[31:0]), 64'h0000_0000_DEAD_BEEF);

        // Subword write and reads.
        applyStimulus(3'd2, 8'h10, 32'h0000_0020, 2'd0, 32'h11223344, 0, 1'b0, resp);
        applyStimulus(3'd1, 8'h11, 32'h0000_0021, 2'd1, 32'h000000AA, 0, 1'b0, resp);
        applyStimulus(3'd0, 8'h12, 32'h0000_0020, 2'd0, 32'h0, 0, 1'b0, resp);
        checkOutput("t2_word_read", 64'(resp[31:0]), 64'h0000_0000_1122_AA44);
        applyStimulus(3'd0, 8'h13, 32'h0000_0022, 2'd2, 32'h0, 0, 1'b0, resp);
        checkOutput("t2_half_read", 64'(resp[31:0]), 64'h0000_0000_0000_1122);
        applyStimulus(3'd0, 8'h14, 32'h0000_0023, 2'd0, 32'h0, 0, 1'b0, resp);
        checkOutput("t2_lane_drop", 64'(resp[31:0]), 64'h0000_0000_0000_0011);

        // Backpressure for five cycles.
        applyStimulus(3'd0, 8'h20, 32'h0000_0020, 2'd0, 32'h0, 5, 1'b0, resp);

        // Flush pulsed while the read is in flight.
        applyStimulus(3'd0, 8'h30, 32'h0000_0010, 2'd0, 32'h0, 2, 1'b1, resp);

        // Address wrap.
        applyStimulus(3'd1, 8'h40, 32'h0000_0400, 2'd0, 32'h0000_0001, 0, 1'b0, resp);
        applyStimulus(3'd0, 8'h41, 32'h0000_0000, 2'd0, 32'h0, 0, 1'b0, resp);
        checkOutput("t5_wrap_read", 64'(resp[31:0]), 64'd1);

        // Flush held high in IDLE with a competing request: flush wins, done every other cycle.
        @(negedge clk);
        flush      = 1'b1;
        memreq_val = 1'b1;
        memreq_msg = {3'd1, 8'h50, 32'h0000_0000, 2'd0, 32'hFFFF_FFFF};
        for (int i = 0; i < 6; i++) begin
            #1;
            checkOutput("flush_hold_done", 64'(flush_done), 64'(i % 2));
            checkOutput("flush_hold_rdy", 64'(memreq_rdy), 64'd0);
            checkOutput("flush_hold_noresp", 64'(memresp_val), 64'd0);
            @(negedge clk);
        end
        flush      = 1'b0;
        memreq_val = 1'b0;
        #1;
        checkOutput("flush_release_done", 64'(flush_done), 64'd0);
        checkOutput("flush_release_rdy", 64'(memreq_rdy), 64'd1);
        applyStimulus(3'd0, 8'h51, 32'h0000_0000, 2'd0, 32'h0, 0, 1'b0, resp);
        checkOutput("flush_req_dropped", 64'(resp[31:0]), 64'd1);

        // Reset while waiting: the response is dropped, array contents survive.
        @(negedge clk);
        memreq_msg = {3'd0, 8'h60, 32'h0000_0020, 2'd0, 32'h0};
        memreq_val = 1'b1;
        #1;
        checkOutput("t6_accept", 64'(memreq_rdy), 64'd1);
        @(negedge clk);
        memreq_val = 1'b0;
        reset      = 1'b1;
        #1;
        checkOutput("t6_rst_rdy", 64'(memreq_rdy), 64'd0);
        checkOutput("t6_rst_val", 64'(memresp_val), 64'd0);
        @(negedge clk);
        reset       = 1'b0;
        memresp_rdy = 1'b1;
        #1;
        checkOutput("t6_rdy_after_rst", 64'(memreq_rdy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t6_no_resp", 64'(memresp_val), 64'd0);
            @(negedge clk);
            #1;
        end
        memresp_rdy = 1'b0;
        applyStimulus(3'd0, 8'h61, 32'h0000_0010, 2'd0, 32'h0, 0, 1'b0, resp);
        checkOutput("t6_retained", 64'(resp[31:0]), 64'h0000_0000_DEAD_BEEF);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            r   = $urandom_range(0, 9);
            typ = (r < 4) ? 3'd0 : (r < 7) ? 3'd1 : (r < 8) ? 3'd2 : 3'($urandom_range(3, 7));
            applyStimulus(typ, 8'($urandom), $urandom, 2'($urandom_range(0, 3)), $urandom,
                          $urandom_range(0, 3), ($urandom_range(0, 9) == 0), resp);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
